// File: rtl/fourphase_rx_if.sv
// Bundles the upstream 4-phase req/ack/data channel and the downstream valid/ready/data beat
// seen by fourphase_rx; slave is the receiver side, master the upstream/consumer side.
interface fourphase_rx_if #(
  parameter int DataWidth = 32
);

  logic                 req_i;
  logic [DataWidth-1:0] data_i;
  logic                 ack_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [DataWidth-1:0] data_o;

  modport slave (
    input  req_i,
    input  data_i,
    input  ready_i,
    output ack_o,
    output valid_o,
    output data_o
  );

  modport master (
    output req_i,
    output data_i,
    output ready_i,
    input  ack_o,
    input  valid_o,
    input  data_o
  );

endinterface

// File: rtl/fourphase_rx.sv
// Receiving end of a 4-phase req/ack channel; each accepted req rise becomes one valid/ready beat
// through a small FIFO. Define FOURPHASE_RX_SYNC_EN to put a 2-flop synchronizer ahead of req_q.
module fourphase_rx #(
  parameter int DataWidth = 32,
  parameter int Depth     = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fourphase_rx_if.slave  bus
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic                 req_q;
  logic                 ack_q;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 not_empty;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [DataWidth-1:0] mem_q [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

`ifdef FOURPHASE_RX_SYNC_EN
  logic req_meta;
  logic req_sync;

  // req_q becomes the third flop so an asynchronous upstream clock is tolerated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      req_meta <= bus.req_i;
      req_sync <= req_meta;
      req_q    <= req_sync;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
    end else begin
      req_q <= bus.req_i;
    end
  end
`endif

  assign full      = (count_q == FullCnt);
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.ready_i;

  // A word is taken only from IDLE, so a held-high req is never pushed twice.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_q && !full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.valid_o = not_empty;
  assign bus.data_o  = mem_q[rd_ptr_q];

endmodule
